// File: rtl/bitstream_pkg.sv
// rtl/bitstream_pkg.sv - shared constants and state encoding for the RLE byte serializer/demux pair
package bitstream_pkg;

  localparam int MAX_PAIRS = 64;
  localparam int PAIR_W    = 16;
  localparam int BLOCK_W   = MAX_PAIRS * PAIR_W;
  localparam int CNT_W     = 7;
  localparam int IDX_W     = 6;

  // Saturation value of the pair index, sized to the counter.
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PAIRS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_PRESENT = 2'd2
  } state_t;

endpackage

// File: rtl/bitstream_demux_if.sv
// rtl/bitstream_demux_if.sv - byte stream in and parallel RLE block out
interface bitstream_demux_if;
  import bitstream_pkg::*;

  logic [7:0]         byte_in;
  logic               byte_valid;
  logic [1:0]         byte_channel_id;
  logic               block_end;
  logic               byte_ready;

  logic [BLOCK_W-1:0] rle_block;
  logic [CNT_W-1:0]   pair_count;
  logic [1:0]         rle_channel_id;
  logic               rle_valid;
  logic               rle_ready;

  modport master (
    output byte_in, byte_valid, byte_channel_id, block_end, rle_ready,
    input  byte_ready, rle_block, pair_count, rle_channel_id, rle_valid
  );

  modport slave (
    input  byte_in, byte_valid, byte_channel_id, block_end, rle_ready,
    output byte_ready, rle_block, pair_count, rle_channel_id, rle_valid
  );

endinterface

// File: rtl/byte_pair_assembler.sv
// rtl/byte_pair_assembler.sv - pairs consecutive bytes into 16-bit RLE words, high byte first
module byte_pair_assembler
  import bitstream_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              byte_wr,
  input  logic [7:0]        byte_in,
  output logic              pair_wr,
  output logic [PAIR_W-1:0] pair_data,
  output logic              pending
);

  logic [7:0] hi_q;
  logic       have_hi;

  // Hold the high half until its low partner arrives; a block close drops any orphan.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      hi_q    <= 8'h00;
      have_hi <= 1'b0;
    end else if (byte_wr) begin
      if (!have_hi) begin
        hi_q    <= byte_in;
        have_hi <= 1'b1;
      end else begin
        have_hi <= 1'b0;
      end
    end
  end

  // The low byte completes the pair in the same cycle it is accepted.
  always_comb begin
    pair_wr   = byte_wr & have_hi;
    pair_data = {hi_q, byte_in};
    pending   = have_hi;
  end

endmodule

// File: rtl/bitstream_demux.sv
// rtl/bitstream_demux.sv - reassembles a serialized RLE byte stream into a parallel 64-pair block
module bitstream_demux
  import bitstream_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  bitstream_demux_if.slave bus,
  output logic             frame_err,
  output logic             overflow,
  output logic             drop_err,
  output logic             busy
);

  state_t state, state_next;

  logic [MAX_PAIRS-1:0][PAIR_W-1:0] pair_buf;
  logic [CNT_W-1:0]  pair_idx;
  logic [1:0]        chan_q;
  logic              ferr_flag, ovf_flag;
  logic              pres_first;
  logic              byte_ready_q;

  logic              in_idle, in_coll, chan_ok, room;
  logic              byte_acc, close, ch_bad, ovf_drop, odd_close, accept, offend;
  logic              pair_wr, pending;
  logic [PAIR_W-1:0] pair_data;

  // Input qualification: which incoming byte/strobe is taken, dropped, or closes the block.
  always_comb begin
    in_idle   = (state == S_IDLE) && byte_ready_q && enable;
    in_coll   = (state == S_COLLECT);
    chan_ok   = (bus.byte_channel_id == chan_q);
    room      = (pair_idx != MAX_CNT);
    byte_acc  = bus.byte_valid && (in_idle || (in_coll && chan_ok && room));
    close     = bus.block_end && (in_idle || in_coll);
    ch_bad    = in_coll && bus.byte_valid && !chan_ok;
    ovf_drop  = in_coll && bus.byte_valid && chan_ok && !room;
    odd_close = close && (pending ^ byte_acc);
    accept    = (state == S_PRESENT) && bus.rle_ready;
    offend    = (bus.byte_valid || bus.block_end) && !byte_ready_q;
  end

  byte_pair_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (close),
    .byte_wr   (byte_acc),
    .byte_in   (bus.byte_in),
    .pair_wr   (pair_wr),
    .pair_data (pair_data),
    .pending   (pending)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic; the unused encoding falls back to idle.
  always_comb begin
    state_next = S_IDLE;
    case (state)
      S_IDLE: begin
        if (close)         state_next = S_PRESENT;
        else if (byte_acc) state_next = S_COLLECT;
        else               state_next = S_IDLE;
      end
      S_COLLECT: state_next = close  ? S_PRESENT : S_COLLECT;
      S_PRESENT: state_next = accept ? S_IDLE    : S_PRESENT;
      default:   state_next = S_IDLE;
    endcase
  end

  // State-decoded outputs and the block bus.
  always_comb begin
    busy               = (state == S_COLLECT) || (state == S_PRESENT);
    bus.rle_valid      = (state == S_PRESENT);
    bus.byte_ready     = byte_ready_q;
    bus.rle_block      = pair_buf;
    bus.pair_count     = pair_idx;
    bus.rle_channel_id = chan_q;
  end

  // Pair buffer, channel latch, sticky error flags and their one-cycle pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      pair_buf     <= '0;
      pair_idx     <= '0;
      chan_q       <= 2'd0;
      ferr_flag    <= 1'b0;
      ovf_flag     <= 1'b0;
      pres_first   <= 1'b0;
      byte_ready_q <= 1'b0;
      frame_err    <= 1'b0;
      overflow     <= 1'b0;
      drop_err     <= 1'b0;
    end else begin
      byte_ready_q <= (state_next != S_PRESENT);
      drop_err     <= offend;
      pres_first   <= (state_next == S_PRESENT) && (state != S_PRESENT);
      frame_err    <= pres_first && ferr_flag;
      overflow     <= pres_first && ovf_flag;

      if (pres_first) begin
        ferr_flag <= 1'b0;
        ovf_flag  <= 1'b0;
      end else begin
        if (ch_bad || odd_close) ferr_flag <= 1'b1;
        if (ovf_drop)            ovf_flag  <= 1'b1;
      end

      if (in_idle && (bus.byte_valid || bus.block_end)) chan_q <= bus.byte_channel_id;

      if (accept) begin
        pair_buf <= '0;
        pair_idx <= '0;
      end else if (pair_wr) begin
        pair_buf[pair_idx[IDX_W-1:0]] <= pair_data;
        pair_idx                      <= pair_idx + 7'd1;
      end
    end
  end

endmodule

// File: tb/tb_bitstream_demux.sv
// tb/tb_bitstream_demux.sv - scoreboard bench for bitstream_demux
module tb_bitstream_demux;
  import bitstream_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic frame_err, overflow, drop_err, busy;

  bitstream_demux_if bus ();

  bitstream_demux dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .bus       (bus),
    .frame_err (frame_err),
    .overflow  (overflow),
    .drop_err  (drop_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BLOCK_W-1:0] blk;
    int cnt;
    int ch;
    int ferr;
    int ovf;
    int drop;
    int lat;
  } exp_t;

  exp_t exp_q[$];

  int cyc = 0;
  int last_byte_cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  bit rst_chk_req = 1'b0;
  bit stim_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] b, input logic [1:0] ch);
    bus.byte_in = b;
    bus.byte_channel_id = ch;
    bus.byte_valid = 1'b1;
    last_byte_cyc = cyc;
    cycle();
    bus.byte_valid = 1'b0;
  endtask

  task automatic close_blk(input logic [1:0] ch);
    bus.byte_channel_id = ch;
    bus.block_end = 1'b1;
    cycle();
    bus.block_end = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  function automatic exp_t new_exp(input int cnt, input int ch, input int ferr,
                                   input int ovf, input int drop, input int lat);
    exp_t e;
    e.blk = '0;
    e.cnt = cnt;
    e.ch = ch;
    e.ferr = ferr;
    e.ovf = ovf;
    e.drop = drop;
    e.lat = lat;
    return e;
  endfunction

  // Stimulus: directed blocks with hand-computed expected results pushed to the scoreboard.
  initial begin : stimulus
    exp_t e;
    rst = 1'b1;
    enable = 1'b1;
    bus.byte_in = 8'h00;
    bus.byte_valid = 1'b0;
    bus.byte_channel_id = 2'd0;
    bus.block_end = 1'b0;
    bus.rle_ready = 1'b1;
    cycle();
    rst_chk_req = 1'b1;
    cycle();
    rst_chk_req = 1'b0;
    rst = 1'b0;
    idle(3);

    // Three clean pairs on channel 2, block_end one cycle after the last byte.
    e = new_exp(3, 2, 0, 0, 0, 2);
    e.blk[0*16 +: 16] = 16'h1234;
    e.blk[1*16 +: 16] = 16'hABCD;
    e.blk[2*16 +: 16] = 16'h00FF;
    exp_q.push_back(e);
    put(8'h12, 2); put(8'h34, 2); put(8'hAB, 2);
    put(8'hCD, 2); put(8'h00, 2); put(8'hFF, 2);
    close_blk(2);
    idle(4);

    // Odd byte count: trailing high byte discarded, frame error.
    e = new_exp(2, 0, 1, 0, 0, -1);
    e.blk[0*16 +: 16] = 16'h1122;
    e.blk[1*16 +: 16] = 16'h3344;
    exp_q.push_back(e);
    put(8'h11, 0); put(8'h22, 0); put(8'h33, 0); put(8'h44, 0); put(8'h55, 0);
    close_blk(0);
    idle(4);

    // 65 pairs: the 65th is dropped and overflow reported.
    e = new_exp(64, 1, 0, 1, 0, -1);
    for (int k = 0; k < 65; k++) begin
      put(8'(k), 1);
      put(8'(k) ^ 8'hA5, 1);
      if (k < 64) e.blk[k*16 +: 16] = {8'(k), 8'(k) ^ 8'hA5};
    end
    exp_q.push_back(e);
    close_blk(1);
    idle(4);

    // Consumer stalls 10 cycles while the source keeps talking: three drops.
    e = new_exp(1, 3, 0, 0, 3, -1);
    e.blk[0*16 +: 16] = 16'hBEEF;
    exp_q.push_back(e);
    bus.rle_ready = 1'b0;
    put(8'hBE, 3); put(8'hEF, 3);
    close_blk(3);
    for (int i = 0; i < 10; i++) begin
      if (i == 2 || i == 6) begin
        bus.byte_valid = 1'b1;
        bus.byte_in = 8'h77;
      end
      if (i == 4) bus.block_end = 1'b1;
      cycle();
      bus.byte_valid = 1'b0;
      bus.block_end = 1'b0;
    end
    bus.rle_ready = 1'b1;
    idle(4);

    // Empty block on channel 1.
    e = new_exp(0, 1, 0, 0, 0, -1);
    exp_q.push_back(e);
    close_blk(1);
    idle(4);

    // Foreign-channel byte mid-block is dropped and flagged.
    e = new_exp(2, 0, 1, 0, 0, -1);
    e.blk[0*16 +: 16] = 16'h0102;
    e.blk[1*16 +: 16] = 16'h0304;
    exp_q.push_back(e);
    put(8'h01, 0); put(8'h02, 0); put(8'h99, 3); put(8'h03, 0); put(8'h04, 0);
    close_blk(0);
    idle(4);

    // Reset after three bytes discards the block silently.
    put(8'hAA, 1); put(8'hBB, 1); put(8'hCC, 1);
    rst = 1'b1;
    cycle();
    rst_chk_req = 1'b1;
    cycle();
    rst_chk_req = 1'b0;
    rst = 1'b0;
    idle(2);

    e = new_exp(2, 2, 0, 0, 0, -1);
    e.blk[0*16 +: 16] = 16'h5AA5;
    e.blk[1*16 +: 16] = 16'hC33C;
    exp_q.push_back(e);
    put(8'h5A, 2); put(8'hA5, 2); put(8'hC3, 2); put(8'h3C, 2);
    close_blk(2);
    idle(4);

    // Disabled while idle: a byte and a block_end must both be ignored.
    enable = 1'b0;
    put(8'h42, 1);
    close_blk(1);
    enable = 1'b1;
    idle(4);

    stim_done = 1'b1;
  end

  task automatic chk(input string name, input longint act, input longint expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic chk_blk(input string name, input logic [BLOCK_W-1:0] act,
                         input logic [BLOCK_W-1:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h", name, act);
      $display("     %s: expected %0h", name, expv);
    end
  endtask

  // Monitor: pops the scoreboard on each accepted block and audits pulses and stability.
  initial begin : monitor
    exp_t e_pop;
    exp_t e_win;
    bit win_pending = 1'b0;
    bit prev_valid = 1'b0;
    bit prev_acc = 1'b0;
    logic [BLOCK_W-1:0] prev_blk = '0;
    logic [CNT_W-1:0] prev_cnt = '0;
    logic [1:0] prev_ch = '0;
    int ferr_cnt = 0;
    int ovf_cnt = 0;
    int drop_cnt = 0;
    int done_wait = 0;
    forever begin
      @(negedge clk);
      if (rst_chk_req) begin
        chk("rst_rle_valid", bus.rle_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_byte_ready", bus.byte_ready, 0);
        chk("rst_pair_count", bus.pair_count, 0);
        chk("rst_channel", bus.rle_channel_id, 0);
        chk("rst_err_pulses", {frame_err, overflow, drop_err}, 0);
        chk_blk("rst_block", bus.rle_block, '0);
      end
      if (!rst) begin
        ferr_cnt += int'(frame_err);
        ovf_cnt += int'(overflow);
        drop_cnt += int'(drop_err);
        if (win_pending) begin
          chk("frame_err_pulses", ferr_cnt, e_win.ferr);
          chk("overflow_pulses", ovf_cnt, e_win.ovf);
          chk("drop_err_pulses", drop_cnt, e_win.drop);
          ferr_cnt = 0;
          ovf_cnt = 0;
          drop_cnt = 0;
          win_pending = 1'b0;
        end
        if (bus.rle_valid && !prev_valid) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_block: got rle_valid=1 expected no block at cycle %0d", cyc);
          end else if (exp_q[0].lat >= 0) begin
            chk("rle_valid_latency", cyc - last_byte_cyc, exp_q[0].lat);
          end
        end
        if (bus.rle_valid && prev_valid && !prev_acc) begin
          chk_blk("held_block", bus.rle_block, prev_blk);
          chk("held_count", bus.pair_count, prev_cnt);
          chk("held_channel", bus.rle_channel_id, prev_ch);
        end
        if (bus.rle_valid && bus.rle_ready && exp_q.size() > 0) begin
          e_pop = exp_q.pop_front();
          chk("pair_count", bus.pair_count, e_pop.cnt);
          chk("channel", bus.rle_channel_id, e_pop.ch);
          chk_blk("block", bus.rle_block, e_pop.blk);
          e_win = e_pop;
          win_pending = 1'b1;
        end
      end
      prev_valid = bus.rle_valid;
      prev_acc = bus.rle_valid && bus.rle_ready;
      prev_blk = bus.rle_block;
      prev_cnt = bus.pair_count;
      prev_ch = bus.rle_channel_id;

      if (stim_done) begin
        done_wait++;
        if (exp_q.size() == 0 && !win_pending && done_wait >= 3) begin
          chk("stray_frame_err", ferr_cnt, 0);
          chk("stray_overflow", ovf_cnt, 0);
          chk("stray_drop_err", drop_cnt, 0);
          $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
          $finish;
        end else if (done_wait > 300) begin
          n_tests++;
          n_fail++;
          $display("FAIL drain_timeout: got %0d blocks outstanding expected 0", exp_q.size());
          $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
          $finish;
        end
      end else if (cyc > 20000) begin
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: got cycle %0d expected stimulus done", cyc);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
      end
    end
  end

endmodule
